// File: rtl/lut_pkg.sv
// lut_pkg: mode encodings and sizing helpers shared by the multimode LUT.
package lut_pkg;
   localparam logic [1:0] LUT_MODE_ROM = 2'b00;
   localparam logic [1:0] LUT_MODE_RAM = 2'b01;
   localparam logic [1:0] LUT_MODE_SRL = 2'b10;
   function automatic int num_chunks(input int mem_size, input int cw);
      return mem_size / cw;
   endfunction
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader: counts configuration chunks and flags when a full image is loaded.
module lut_cfg_loader
   import lut_pkg::*;
#(
   parameter int NUM_CHUNKS = 4,
   parameter int CNT_W = cnt_width(NUM_CHUNKS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             config_en,
   output logic             chunk_we,
   output logic [CNT_W-1:0] chunk_idx,
   output logic             config_done
);
   logic [CNT_W-1:0] cnt;
   logic last;
   assign last = cnt == CNT_W'(NUM_CHUNKS - 1);
   assign chunk_we = config_en;
   assign chunk_idx = cnt;
   // the final chunk wins over the reload clear, so a single-chunk image ends done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         config_done <= 1'b0;
      end else if (config_en) begin
         cnt <= last ? '0 : cnt + CNT_W'(1);
         config_done <= last ? 1'b1 : (cnt == '0) ? 1'b0 : config_done;
      end
   end
endmodule

// File: rtl/lut_m_multimode.sv
// lut_m_multimode: LUT / distributed RAM / variable-tap SRL with a chunked config loader.
module lut_m_multimode
   import lut_pkg::*;
#(
   parameter int INPUTS = 4,
   parameter int MEM_SIZE = 2**INPUTS,
   parameter int CONFIG_WIDTH = 4,
   parameter int OUT_REG = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [INPUTS-1:0]       addr,
   output logic                    out,
   input  logic                    config_en,
   input  logic [CONFIG_WIDTH-1:0] config_in,
   output logic                    config_done,
   input  logic [1:0]              mode,
   input  logic                    data_in,
   input  logic                    write_en,
   input  logic [INPUTS-1:0]       waddr,
   output logic                    shift_out
);
   localparam int NUM_CHUNKS = num_chunks(MEM_SIZE, CONFIG_WIDTH);
   localparam int CNT_W = cnt_width(NUM_CHUNKS);
   logic [MEM_SIZE-1:0] mem, mem_nxt;
   logic chunk_we;
   logic [CNT_W-1:0] chunk_idx;
   lut_cfg_loader #(.NUM_CHUNKS(NUM_CHUNKS), .CNT_W(CNT_W)) u_loader (
      .clk(clk),
      .rst_n(rst_n),
      .config_en(config_en),
      .chunk_we(chunk_we),
      .chunk_idx(chunk_idx),
      .config_done(config_done)
   );
   // config writes take priority; user writes need a complete image
   always_comb begin
      mem_nxt = mem;
      if (chunk_we) begin
         for (int i = 0; i < NUM_CHUNKS; i++)
            if (chunk_idx == CNT_W'(i)) mem_nxt[i*CONFIG_WIDTH +: CONFIG_WIDTH] = config_in;
      end else if (config_done && write_en) begin
         if (mode == LUT_MODE_RAM) mem_nxt[waddr] = data_in;
         else if (mode == LUT_MODE_SRL) mem_nxt = {mem[MEM_SIZE-2:0], data_in};
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mem <= '0;
      else mem <= mem_nxt;
   end
   assign shift_out = mem[MEM_SIZE-1];
   generate
      if (OUT_REG != 0) begin : g_reg
         logic rd_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) rd_q <= 1'b0;
            else rd_q <= mem[addr];
         end
         assign out = rd_q;
      end else begin : g_comb
         assign out = mem[addr];
      end
   endgenerate
endmodule

// File: tb/tb_lut_m_multimode.sv
// tb_lut_m_multimode: directed checks of both read variants driven by one stimulus stream.
module tb_lut_m_multimode;
   logic clk = 1'b0;
   logic rst_n;
   logic [3:0] addr, waddr, config_in;
   logic [1:0] mode;
   logic config_en, data_in, write_en;
   logic out0, out1, done0, done1, so0, so1;
   int checks = 0;
   int failures = 0;
   logic [15:0] img, got;

   always #5 clk = ~clk;

   lut_m_multimode #(.OUT_REG(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .addr(addr), .out(out0), .config_en(config_en),
      .config_in(config_in), .config_done(done0), .mode(mode), .data_in(data_in),
      .write_en(write_en), .waddr(waddr), .shift_out(so0)
   );
   lut_m_multimode #(.OUT_REG(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .addr(addr), .out(out1), .config_en(config_en),
      .config_in(config_in), .config_done(done1), .mode(mode), .data_in(data_in),
      .write_en(write_en), .waddr(waddr), .shift_out(so1)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_chunks(input logic [15:0] im, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         config_en = 1'b1;
         config_in = im[i*4 +: 4];
         step();
         chk($sformatf("done_chunk%0d", i), {15'd0, done0}, {15'd0, i == 3});
      end
      config_en = 1'b0;
   endtask

   task automatic read_image(output logic [15:0] v);
      for (int a = 0; a < 16; a++) begin
         addr = 4'(a);
         #1;
         v[a] = out0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; addr = '0; waddr = '0; config_in = '0; mode = 2'b00;
      config_en = 1'b0; data_in = 1'b0; write_en = 1'b0;
      #11;
      chk("rst_out", {15'd0, out0}, 16'd0);
      chk("rst_out_reg", {15'd0, out1}, 16'd0);
      chk("rst_done", {15'd0, done0}, 16'd0);
      chk("rst_shift_out", {15'd0, so0}, 16'd0);
      #1 rst_n = 1'b1;
      // 1: straight load and full sweep
      img = 16'hA5C3;
      load_chunks(img, 0, 3);
      for (int a = 0; a < 16; a++) begin
         addr = 4'(a);
         #1;
         chk($sformatf("t1_bit%0d", a), {15'd0, out0}, {15'd0, img[a]});
      end
      // 2: load with a gap, then a reload drops done
      load_chunks(img, 0, 1);
      step(); step(); step();
      chk("t2_gap_done", {15'd0, done0}, 16'd0);
      load_chunks(img, 2, 3);
      read_image(got);
      chk("t2_image", got, 16'hA5C3);
      load_chunks(16'h0000, 0, 0);
      // 3: RAM writes blocked before done, allowed after, blocked during config
      mode = 2'b01; waddr = 4'd5; data_in = 1'b1; write_en = 1'b1; addr = 4'd5;
      step();
      chk("t3_blocked_write", {15'd0, out0}, 16'd0);
      write_en = 1'b0;
      load_chunks(16'h0000, 1, 3);
      write_en = 1'b1;
      #1;
      chk("t3_before_edge", {15'd0, out0}, 16'd0);
      step();
      chk("t3_after_edge", {15'd0, out0}, 16'd1);
      config_en = 1'b1; config_in = 4'hF; waddr = 4'd8;
      step();
      config_en = 1'b0; write_en = 1'b0;
      chk("t3_cfg_prio_done", {15'd0, done0}, 16'd0);
      load_chunks(16'h0000, 1, 3);
      read_image(got);
      chk("t3_cfg_prio_image", got, 16'h000F);
      load_chunks(16'h0000, 0, 3);
      // 4: SRL tap 3 and cascade output
      mode = 2'b10; addr = 4'd3; write_en = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         data_in = (k == 1);
         step();
         chk($sformatf("t4_tap_shift%0d", k), {15'd0, out0}, {15'd0, k == 4});
         chk($sformatf("t4_so_shift%0d", k), {15'd0, so0}, {15'd0, k == 16});
      end
      write_en = 1'b0;
      step(); step();
      chk("t4_hold_so", {15'd0, so0}, 16'd1);
      mode = 2'b00; write_en = 1'b1; data_in = 1'b0;
      step();
      write_en = 1'b0;
      chk("t4_lut_ignores_we", {15'd0, so0}, 16'd1);
      // 5: async reset mid-load
      load_chunks(16'hFFFF, 0, 1);
      addr = 4'd0;
      #1;
      chk("t5_pre_rst_out", {15'd0, out0}, 16'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_out", {15'd0, out0}, 16'd0);
      chk("t5_rst_out_reg", {15'd0, out1}, 16'd0);
      chk("t5_rst_done", {15'd0, done0}, 16'd0);
      chk("t5_rst_so", {15'd0, so0}, 16'd0);
      #1 rst_n = 1'b1;
      load_chunks(img, 0, 3);
      read_image(got);
      chk("t5_image", got, 16'hA5C3);
      // 6: registered read latency on a RAM write
      mode = 2'b01; addr = 4'd2; waddr = 4'd2; data_in = 1'b1;
      step();
      chk("t6_reg_old", {15'd0, out1}, 16'd0);
      write_en = 1'b1;
      step();
      write_en = 1'b0;
      chk("t6_reg_edge_n", {15'd0, out1}, 16'd0);
      chk("t6_comb_edge_n", {15'd0, out0}, 16'd1);
      step();
      chk("t6_reg_edge_n1", {15'd0, out1}, 16'd1);
      mode = 2'b11; data_in = 1'b0; write_en = 1'b1;
      step();
      write_en = 1'b0;
      chk("t6_reserved_mode", {15'd0, out0}, 16'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
